// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 host transmit path:
//                FSM state encoding, error codes and keyboard command bytes.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Parity bit that makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_filter
//  Description : Conditions one raw PS/2 pin: 2-FF synchroniser, deglitch
//                requiring FILTER_LEN consecutive equal samples before the
//                filtered level changes, and a one-cycle falling-edge strobe
//                aligned with the filtered level change.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int              c_cnt_w = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(FILTER_LEN - 1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_fall;
    logic               w_diff;

    assign w_diff = r_sync[1] ^ r_level;
    assign level  = r_level;
    assign fall   = r_fall;

    // Two-stage synchroniser; the idle bus is pulled high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], line_in};
        end
    end

    // Deglitch: flip the filtered level only after a run of FILTER_LEN
    // samples that disagree with it; strobe fall when it flips 1 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (w_diff) begin
                if (r_cnt == c_last) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                    r_fall  <= r_level;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//                request-to-send, shifts out 8 data bits, odd parity and stop
//                on device clock falling edges, then checks the device ACK.
//                Timeouts and missing ACKs are reported on error/err_code.
//                Optional build macro PS2_HOST_TX_RETRY_EN: retry a failed
//                frame up to 2 times before reporting an error.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 720,
    parameter int TIMEOUT_CYCLES = 90000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int                  c_inh_w   = $clog2(INHIBIT_CYCLES + 1);
    localparam int                  c_wd_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_inh_w-1:0]  c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_wd_w-1:0]   c_wd_last  = c_wd_w'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]          c_last_bit = 4'd9;

    ps2_tx_state_t      r_state;
    logic [9:0]         r_shift;
    logic [c_inh_w-1:0] r_inh_cnt;
    logic [3:0]         r_bit_cnt;
    logic [c_wd_w-1:0]  r_wd;
    logic               r_tx_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [1:0]         r_err_code;
    logic               r_clk_oe;
    logic               r_data_oe;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam logic [1:0] c_max_retry = 2'd2;
    logic [1:0]         r_retry;
`endif

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_data_lvl;
    logic w_data_fall_unused;
    logic w_active;
    logic w_bus_idle;
    logic w_nak;
    logic w_timeout;
    logic w_fail;
    logic [1:0] w_fail_code;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_clk_in),
        .level   (w_clk_lvl),
        .fall    (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_data_in),
        .level   (w_data_lvl),
        .fall    (w_data_fall_unused)
    );

    // Failure detection: a high data line on the ACK edge is a NAK; the
    // watchdog fires only when no edge or bus-idle event rescues the cycle.
    assign w_active    = (r_state == REQ) || (r_state == SHIFT) ||
                         (r_state == ACK) || (r_state == WAIT_IDLE);
    assign w_bus_idle  = w_clk_lvl & w_data_lvl;
    assign w_nak       = (r_state == ACK) & w_clk_fall & w_data_lvl;
    assign w_timeout   = w_active & (r_wd == c_wd_last) & ~w_clk_fall &
                         ~((r_state == WAIT_IDLE) & w_bus_idle);
    assign w_fail      = w_nak | w_timeout;
    assign w_fail_code = w_nak ? ERR_NOACK : ERR_TIMEOUT;

    assign tx_ready    = r_tx_ready;
    assign busy        = r_busy;
    assign rx_inhibit  = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign err_code    = r_err_code;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

    // Transmit sequencer with registered outputs and device watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_inh_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_wd       <= '0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            r_retry    <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;

            if (w_active) begin
                if (w_clk_fall) begin
                    r_wd <= '0;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end

            if (w_fail) begin
                r_err_code <= w_fail_code;
`ifdef PS2_HOST_TX_RETRY_EN
                if (r_retry != c_max_retry) begin
                    // Same byte again from a fresh inhibit; busy stays high.
                    r_retry   <= r_retry + 1'b1;
                    r_state   <= INHIBIT;
                    r_clk_oe  <= 1'b1;
                    r_data_oe <= 1'b0;
                    r_inh_cnt <= '0;
                end else
`endif
                begin
                    r_state    <= IDLE;
                    r_error    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_clk_oe   <= 1'b0;
                    r_data_oe  <= 1'b0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (tx_valid) begin
                            r_shift    <= {1'b1, odd_parity(tx_data), tx_data};
                            r_err_code <= ERR_NONE;
                            r_tx_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_clk_oe   <= 1'b1;
                            r_inh_cnt  <= '0;
                            r_state    <= INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                            r_retry    <= '0;
`endif
                        end
                    end
                    INHIBIT: begin
                        // Clock held low; the final cycle adds the start bit
                        // before the clock is released.
                        if (r_data_oe) begin
                            r_clk_oe  <= 1'b0;
                            r_bit_cnt <= '0;
                            r_wd      <= '0;
                            r_state   <= REQ;
                        end else begin
                            if (r_inh_cnt == c_inh_last) begin
                                r_data_oe <= 1'b1;
                            end
                            r_inh_cnt <= r_inh_cnt + 1'b1;
                        end
                    end
                    REQ: begin
                        if (w_clk_fall) begin
                            r_data_oe <= ~r_shift[0];
                            r_bit_cnt <= 4'd1;
                            r_state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (w_clk_fall) begin
                            r_data_oe <= ~r_shift[r_bit_cnt];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_last_bit) begin
                                r_state <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (w_clk_fall) begin
                            r_state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (w_bus_idle) begin
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_tx_ready <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with an open-drain bus,
//                a behavioural keyboard model and a scoreboard monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int T_INH = 720;
    localparam int T_TO  = 2000;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, error, rx_inhibit;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;

    assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(T_INH), .TIMEOUT_CYCLES(T_TO), .FILTER_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .rx_inhibit(rx_inhibit),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [7:0] data;
        logic       is_err;
        logic [1:0] code;
    } exp_t;
    exp_t sb_q[$];

    // mode 0: device clocks and ACKs after naks NAKed attempts; 2: silent
    function automatic exp_t model(input logic [7:0] d, input int mode, input int naks);
        exp_t e;
        e.data = d;
        if (mode == 2) begin
            e.is_err = 1'b1; e.code = 2'b01;
        end else if (naks >= ATTEMPTS) begin
            e.is_err = 1'b1; e.code = 2'b10;
        end else begin
            e.is_err = 1'b0; e.code = 2'b00;
        end
        return e;
    endfunction

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d};
    endfunction

    // ---------------- keyboard model ----------------
    int         dev_mode = 0;
    int         dev_nak_left = 0;
    int         dev_half = 60;
    logic [9:0] dev_bits;
    int         dev_nbits = 0;
    logic       dev_active = 1'b0;

    task automatic dev_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_frame();
        dev_active = 1'b1;
        dev_wait(dev_half);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            dev_wait(dev_half);
            dev_clk_low = 1'b0;
            dev_wait(2);
            dev_bits[i] = ps2_data_in;
            dev_nbits   = i + 1;
            dev_wait(dev_half - 2);
        end
        if (dev_nak_left > 0) dev_nak_left--;
        else dev_data_low = 1'b1;
        dev_wait(dev_half / 2);
        dev_clk_low = 1'b1;
        dev_wait(dev_half);
        dev_clk_low = 1'b0;
        dev_wait(dev_half / 2);
        dev_data_low = 1'b0;
        dev_active = 1'b0;
    endtask

    initial begin : device
        bit saw_inh;
        saw_inh = 1'b0;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        forever begin
            @(negedge clk);
            if (ps2_clk_oe) saw_inh = 1'b1;
            else if (saw_inh && !ps2_data_in && ps2_clk_in) begin
                saw_inh = 1'b0;
                if (dev_mode != 2) do_frame();
            end
        end
    end

    // ---------------- monitor ----------------
    int   cyc = 0, req_cyc = 0, inh_run = 0, inh_phases = 0;
    logic prev_clk_oe = 1'b0, ready_next = 1'b0;
    logic [1:0] last_code = 2'b00;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (prev_clk_oe && !ps2_clk_oe && ps2_data_oe) req_cyc = cyc;
            if (ps2_clk_oe && !ps2_data_oe) inh_run++;
            else if (ps2_clk_oe && ps2_data_oe && inh_run > 0) begin
                chk("inhibit_len", inh_run, T_INH);
                inh_run = 0;
                inh_phases++;
            end else if (!ps2_clk_oe) inh_run = 0;
            if (busy !== rx_inhibit) chk("rx_inhibit", rx_inhibit, busy);
            if (done || error) begin
                exp_t e;
                chk("done_err_exclusive", done & error, 0);
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("error_pulse", error, e.is_err);
                    chk("done_pulse", done, !e.is_err);
                    chk("err_code", err_code, e.code);
                    last_code = e.code;
                    if (!e.is_err) begin
                        chk("dev_nbits", dev_nbits, 10);
                        chk("dev_frame", dev_bits, frame_of(e.data));
                    end
                    if (error) chk("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
                    if (error && e.code == 2'b01) chk("timeout_latency", cyc - req_cyc, T_TO);
                end
                ready_next = 1'b1;
            end else if (ready_next) begin
                chk("ready_after", tx_ready, 1);
                chk("busy_after", busy, 0);
                chk("err_code_held", err_code, last_code);
                ready_next = 1'b0;
            end
        end
        prev_clk_oe = ps2_clk_oe;
    end

    // ---------------- stimulus ----------------
    task automatic wait_dev_idle();
        int n = 0;
        while (dev_active && n < 20000) begin @(negedge clk); n++; end
        chk("dev_idle", dev_active, 0);
    endtask

    task automatic send(input logic [7:0] d, input int mode, input int naks,
                        input int half, input bit poke);
        int n;
        dev_mode = mode; dev_nak_left = naks; dev_half = half; dev_nbits = 0;
        sb_q.push_back(model(d, mode, naks));
        @(negedge clk);
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("clk_oe_after_accept", ps2_clk_oe, 1);
        chk("busy_after_accept", busy, 1);
        n = 0;
        while (busy && n < 40000) begin
            @(negedge clk);
            n++;
            if (poke && n == 300) begin
                tx_data = ~d; tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        end
        chk("txn_complete", busy, 0);
        wait_dev_idle();
        repeat (20) @(negedge clk);
    endtask

    initial begin : stim
        int ph0, n;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_outs", {busy, done, error, rx_inhibit, ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_err_code", err_code, ERR_NONE);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(CMD_SET_LEDS, 0, 0, 240, 1'b0);
        send(CMD_ENABLE,   0, 0, 60,  1'b0);
        send(8'h00,        0, 0, 60,  1'b1);
        send(CMD_RESET,    2, 0, 60,  1'b0);
        send(8'h5A,        0, 3, 60,  1'b0);
`ifdef PS2_HOST_TX_RETRY_EN
        ph0 = inh_phases;
        send(8'hA5,        0, 2, 60,  1'b0);
        chk("retry_inhibit_phases", inh_phases - ph0, 3);
`endif
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), 0, ($urandom_range(0, 3) == 0) ? 1 : 0,
                 $urandom_range(40, 80), 1'b0);
        end

        // Asynchronous reset in the middle of bit 4.
        dev_mode = 0; dev_nak_left = 0; dev_half = 60; dev_nbits = 0;
        @(negedge clk);
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (dev_nbits < 4 && n < 20000) begin @(negedge clk); n++; end
        chk("reached_bit4", dev_nbits >= 4, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_clk_oe_async", ps2_clk_oe, 0);
        chk("rst_data_oe_async", ps2_data_oe, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_dev_idle();
        repeat (20) @(negedge clk);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_busy", busy, 0);

        send(RSP_ACK, 0, 0, 60, 1'b0);
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
